adc_idelay_cal: RTL and testbench
=================================

// Module: adc_idelay_cal
// PURPOSE
//  Automatic IDELAY tap calibration for one deserialised ADC channel, in the clk_div (156.25 MHz) domain.
//  Consumes the 80-bit parallel word from the ADC data receiver while the ADC outputs a fixed test pattern.
//  Sweeps every delay tap and drives the receiver's load / CNTVALUEIN inputs, then applies the centre of the
//  widest error-free window. Invoked after ADC SPI config completes and rst_SERDES is released.
// PARAMETERS
//  TAP_W    9    delay tap width; taps 0..2**TAP_W-1 are swept
//  NSAMP    8    samples per parallel word
//  SMP_W    10   bits per sample; data width = NSAMP*SMP_W
//  SETTLE   16   idle cycles after each load before checking starts
//  DWELL    256  compare cycles per tap
//  MIN_WIN  8    minimum passing-window length for success
// PORTS
//  clk_div       in   1           deserialiser divided clock
//  rst           in   1           asynchronous active-high reset
//  start         in   1           one-cycle pulse; begins calibration
//  data          in   NSAMP*SMP_W receiver parallel word; sample k = data[k*SMP_W +: SMP_W]
//  pattern       in   SMP_W       expected test-pattern value; quasi-static during a run
//  cntvalue_out  in   TAP_W       tap readback from the receiver
//  load          out  1           one-cycle pulse to the receiver delay
//  cntvalue_in   out  TAP_W       tap value presented with load
//  busy          out  1           high from start until done
//  done          out  1           sticky; cleared by the next accepted start
//  fail          out  1           valid when done; 1 = no usable window
//  best_tap      out  TAP_W       applied tap (centre of the window)
//  win_len       out  TAP_W+1     length of the widest window
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; tap, run and best registers 0.
//  FSM states and transitions:
//   IDLE   -> SET on start. Clear done/fail/best/run, tap=0, busy=1.
//   SET    -> SETTLE. load=1 for exactly 1 cycle with cntvalue_in=tap.
//   SETTLE -> CHECK after SETTLE cycles. On the last SETTLE cycle, cntvalue_out!=tap marks the tap as failing.
//   CHECK  -> EVAL after DWELL cycles. The tap fails if any cycle has any sample != pattern.
//             The mismatch flag is sticky within the tap.
//   EVAL   -> SET (tap+1), or FINAL if tap is max. Always 1 cycle.
//             Pass: if run_len==0 then run_start=tap; run_len++.
//             Fail: close the run, then run_len=0.
//   FINAL  -> APPLY. Close any open run; tap max and tap 0 are not adjacent (no wrap-around).
//   APPLY  -> IDLE. load=1 for 1 cycle with cntvalue_in=best_tap. Set done=1, busy=0.
//  Close run: if run_len > best_len (strictly greater), best_start=run_start and best_len=run_len.
//   On ties the lower window wins.
//  best_tap = best_start + ((best_len-1)>>1); the result stays in TAP_W bits by construction.
//   win_len = best_len.
//  If best_len < MIN_WIN: fail=1, best_tap=0, and APPLY loads tap 0. win_len still reports best_len.
//  Per-tap time = 1 + SETTLE + DWELL + 1 cycles; total = 2**TAP_W * that + 2 cycles (FINAL and APPLY).
//  start while busy is ignored. start in the same cycle as the APPLY exit is ignored.
//  Mid-run reset: immediate return to IDLE, outputs 0. No final load is issued.
//  Outside SET and APPLY, load=0. cntvalue_in holds its last value.
// TESTING
//  1. Data always equals pattern, readback echoes tap -> best_tap=255, win_len=512, fail=0.
//     Total 512*274+2 cycles; final load carries 255.
//  2. Bench corrupts one sample bit unless tap is in [100,180] -> best_tap=140, win_len=81, fail=0.
//  3. Pass windows [10,40] and [300,330] (equal length 31) -> best_tap=25, win_len=31.
//     Then widen the second window to [300,331] -> best_tap=315, win_len=32.
//  4. Pass only for taps [50,55] (6 < MIN_WIN) -> done=1, fail=1, best_tap=0, final load carries 0, win_len=6.
//  5. Window [200,260] with one mismatching cycle at DWELL cycle 255 of tap 230 -> windows [200,229] and [231,260].
//     Result best_tap=214, win_len=30. Readback stuck at 0 -> fail=1.
//  6. Assert rst at tap 300 -> next cycle all outputs 0 with no load pulse.
//     A start pulse during busy is ignored; a start after done clears done and repeats scenario 1.

Source files
------------

// File: rtl/adc_idelay_cal.sv
// IDELAY tap sweep for one deserialised ADC lane: scores every tap against a static test pattern,
// then loads the centre of the widest clean window. A full run takes 2**TAP_W*(SETTLE+DWELL+2)+2 cycles.
module adc_idelay_cal #(
  parameter int TAP_W   = 9,
  parameter int NSAMP   = 8,
  parameter int SMP_W   = 10,
  parameter int SETTLE  = 16,
  parameter int DWELL   = 256,
  parameter int MIN_WIN = 8
) (
  input  logic                   clk_div,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NSAMP*SMP_W-1:0] data,
  input  logic [SMP_W-1:0]       pattern,
  input  logic [TAP_W-1:0]       cntvalue_out,
  output logic                   load,
  output logic [TAP_W-1:0]       cntvalue_in,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [TAP_W-1:0]       best_tap,
  output logic [TAP_W:0]         win_len
);

  localparam int MAXC  = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [TAP_W-1:0] TAP_MAX = {TAP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_CHECK, S_EVAL, S_FINAL, S_APPLY
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [TAP_W-1:0]   run_start_q, run_start_d;
  logic [TAP_W:0]     run_len_q, run_len_d;
  logic [TAP_W-1:0]   best_start_q, best_start_d;
  logic [TAP_W:0]     best_len_q, best_len_d;
  logic               load_q, load_d;
  logic [TAP_W-1:0]   cntin_q, cntin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [TAP_W-1:0]   best_tap_q, best_tap_d;
  logic [TAP_W:0]     win_len_q, win_len_d;

  logic               mismatch;
  logic               run_better;
  logic [TAP_W-1:0]   fin_start;
  logic [TAP_W:0]     fin_len;
  logic [TAP_W:0]     fin_half;

  always_comb begin
    mismatch = 1'b0;
    for (int k = 0; k < NSAMP; k++) begin
      if (data[k*SMP_W +: SMP_W] != pattern) mismatch = 1'b1;
    end
  end

  // Strictly greater, so an equal-length later window never displaces an earlier one.
  assign run_better = (run_len_q > best_len_q);
  assign fin_start  = run_better ? run_start_q : best_start_q;
  assign fin_len    = run_better ? run_len_q   : best_len_q;
  assign fin_half   = (fin_len - (TAP_W+1)'(1)) >> 1;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    load_d       = 1'b0;
    cntin_d      = cntin_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    best_tap_d   = best_tap_q;
    win_len_d    = win_len_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SET;
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          best_tap_d   = '0;
          win_len_d    = '0;
          busy_d       = 1'b1;
          load_d       = 1'b1;
          cntin_d      = '0;
        end
      end
      S_SET: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          if (cntvalue_out != tap_q) err_d = 1'b1;
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) err_d = 1'b1;
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EVAL: begin
        if (!err_q) begin
          if (run_len_q == '0) run_start_d = tap_q;
          run_len_d = run_len_q + (TAP_W+1)'(1);
        end else begin
          if (run_better) begin
            best_start_d = run_start_q;
            best_len_d   = run_len_q;
          end
          run_len_d = '0;
        end
        if (tap_q == TAP_MAX) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = S_SET;
          load_d  = 1'b1;
          cntin_d = tap_q + TAP_W'(1);
        end
      end
      S_FINAL: begin
        best_start_d = fin_start;
        best_len_d   = fin_len;
        run_len_d    = '0;
        win_len_d    = fin_len;
        if (fin_len < (TAP_W+1)'(MIN_WIN)) begin
          fail_d     = 1'b1;
          best_tap_d = '0;
        end else begin
          best_tap_d = fin_start + fin_half[TAP_W-1:0];
        end
        cntin_d = best_tap_d;
        load_d  = 1'b1;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      load_q       <= 1'b0;
      cntin_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      best_tap_q   <= '0;
      win_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      load_q       <= load_d;
      cntin_q      <= cntin_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      best_tap_q   <= best_tap_d;
      win_len_q    <= win_len_d;
    end
  end

  assign load        = load_q;
  assign cntvalue_in = cntin_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign best_tap    = best_tap_q;
  assign win_len     = win_len_q;

endmodule

// File: tb/tb_adc_idelay_cal.sv
// Directed bench for adc_idelay_cal with a receiver model that follows load/cntvalue_in.
// Short SETTLE/DWELL keep full 512-tap sweeps cheap; expected results go through a scoreboard queue.
module tb_adc_idelay_cal;
  localparam int TAP_W   = 9;
  localparam int NSAMP   = 8;
  localparam int SMP_W   = 10;
  localparam int SETTLE  = 2;
  localparam int DWELL   = 4;
  localparam int MIN_WIN = 8;
  localparam int DW      = NSAMP * SMP_W;
  localparam int NTAPS   = 1 << TAP_W;
  localparam int RUN_CYC = NTAPS * (1 + SETTLE + DWELL + 1) + 2;
  localparam int LIMIT   = RUN_CYC + 200;

  logic               clk_div = 1'b0;
  logic               rst;
  logic               start;
  logic [DW-1:0]      data;
  logic [SMP_W-1:0]   pattern;
  logic [TAP_W-1:0]   cntvalue_out;
  logic               load;
  logic [TAP_W-1:0]   cntvalue_in;
  logic               busy;
  logic               done;
  logic               fail;
  logic [TAP_W-1:0]   best_tap;
  logic [TAP_W:0]     win_len;

  adc_idelay_cal #(
    .TAP_W(TAP_W), .NSAMP(NSAMP), .SMP_W(SMP_W),
    .SETTLE(SETTLE), .DWELL(DWELL), .MIN_WIN(MIN_WIN)
  ) dut (
    .clk_div(clk_div), .rst(rst), .start(start), .data(data), .pattern(pattern),
    .cntvalue_out(cntvalue_out), .load(load), .cntvalue_in(cntvalue_in), .busy(busy),
    .done(done), .fail(fail), .best_tap(best_tap), .win_len(win_len)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int tap;
    int len;
    int fl;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  int lo1 = 0, hi1 = -1, lo2 = 0, hi2 = -1, glitch_tap = -1;
  bit stuck = 1'b0;
  int clr_req = 0;

  int rx_tap = 0, since = 0, nloads = 0, busy_cyc = 0, seq_err = 0, last_load = -1;

  function automatic bit tap_ok(input int t);
    return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
  endfunction

  // Receiver model plus load/busy monitor, all evaluated on the falling edge.
  initial begin
    int clr_seen;
    logic [DW-1:0] d;
    clr_seen     = 0;
    data         = '0;
    cntvalue_out = '0;
    forever begin
      @(negedge clk_div);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        nloads = 0; busy_cyc = 0; seq_err = 0; last_load = -1;
      end
      if (busy) busy_cyc++;
      if (load) begin
        if (nloads < NTAPS && int'(cntvalue_in) != nloads) seq_err++;
        nloads++;
        last_load = int'(cntvalue_in);
        rx_tap    = int'(cntvalue_in);
        since     = 0;
      end else begin
        since++;
      end
      cntvalue_out = stuck ? '0 : TAP_W'(rx_tap);
      d = {NSAMP{pattern}};
      if (!tap_ok(rx_tap) || (rx_tap == glitch_tap && since == SETTLE + DWELL))
        d[rx_tap % DW] = ~d[rx_tap % DW];
      data = d;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_div);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cal(input string nm, input int a_lo, input int a_hi, input int b_lo,
                         input int b_hi, input int gl, input bit stk, input int e_tap,
                         input int e_len, input int e_fail, input bit full, input bit apply_start);
    exp_t e;
    int cyc;
    lo1 = a_lo; hi1 = a_hi; lo2 = b_lo; hi2 = b_hi; glitch_tap = gl; stuck = stk;
    sb.push_back('{tap: e_tap, len: e_len, fl: e_fail});
    clr_req++;
    tick();
    tick();
    pulse_start();
    check({nm, "_start"}, {30'd0, busy, done}, 32'd2);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      tick();
      cyc++;
      start = (apply_start && load && nloads == NTAPS + 1);
    end
    start = 1'b0;
    check({nm, "_done"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check({nm, "_best_tap"}, best_tap, e.tap);
    check({nm, "_win_len"}, win_len, e.len);
    check({nm, "_fail"}, fail, e.fl);
    check({nm, "_final_load"}, last_load, e.tap);
    if (full) begin
      check({nm, "_nloads"}, nloads, NTAPS + 1);
      check({nm, "_busy_cycles"}, busy_cyc, RUN_CYC);
      check({nm, "_tap_seq"}, seq_err, 0);
    end
    if (apply_start) begin
      tick();
      tick();
      check({nm, "_start_at_apply_ignored"}, {30'd0, busy, done}, 32'd1);
    end
  endtask

  initial begin
    int c;
    int n_at_rst;
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 10'h2A5;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", {load, cntvalue_in, busy, done, fail, best_tap, win_len}, 32'd0);

    run_cal("s1_all_pass", 0, 511, 0, -1, -1, 1'b0, 255, 512, 0, 1'b1, 1'b0);

    pattern = 10'h133;
    run_cal("s2_window", 100, 180, 0, -1, -1, 1'b0, 140, 81, 0, 1'b0, 1'b0);
    pattern = 10'h2A5;

    run_cal("s3_tie", 10, 40, 300, 330, -1, 1'b0, 25, 31, 0, 1'b0, 1'b0);
    run_cal("s3_wider", 10, 40, 300, 331, -1, 1'b0, 315, 32, 0, 1'b0, 1'b0);
    run_cal("s4_narrow", 50, 55, 0, -1, -1, 1'b0, 0, 6, 1, 1'b0, 1'b1);
    run_cal("s5_glitch", 200, 260, 0, -1, 230, 1'b0, 214, 30, 0, 1'b0, 1'b0);
    run_cal("s5_stuck", 0, 511, 0, -1, -1, 1'b1, 0, 1, 1, 1'b0, 1'b0);

    lo1 = 0; hi1 = 511; lo2 = 0; hi2 = -1; glitch_tap = -1; stuck = 1'b0;
    clr_req++;
    tick();
    tick();
    pulse_start();
    check("s6_done_cleared", {30'd0, busy, done}, 32'd2);
    c = 0;
    while (rx_tap != 50 && c < LIMIT) begin tick(); c++; end
    pulse_start();
    tick();
    check("s6_busy_after_start", {31'd0, busy}, 32'd1);
    c = 0;
    while (rx_tap != 300 && c < LIMIT) begin tick(); c++; end
    check("s6_reach_tap300", rx_tap, 300);
    check("s6_no_restart", seq_err, 0);
    rst = 1'b1;
    #1;
    check("s6_rst_outputs", {load, cntvalue_in, busy, done, fail, best_tap, win_len}, 32'd0);
    n_at_rst = nloads;
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("s6_no_load_after_rst", nloads, n_at_rst);
    check("s6_idle_after_rst", {30'd0, busy, done}, 32'd0);

    run_cal("s6_rerun", 0, 511, 0, -1, -1, 1'b0, 255, 512, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
